// File: rtl/image_rom_arbiter.sv
// Shares one image ROM read port between a fixed-latency pixel fetch and a low-priority auxiliary reader.
// Optional auxiliary starvation counter is enabled by defining IMAGE_ROM_ARB_STARVE_CNT_EN.
module image_rom_arbiter #(
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = 24,
  parameter int ROM_LAT = 2
) (
  input  logic              VGA_CLK,
  input  logic              RESET,
  input  logic              PIX_REQ,
  input  logic [ADDR_W-1:0] PIX_ADDR,
  output logic [DATA_W-1:0] PIX_DATA,
  output logic              PIX_VALID,
  input  logic              AUX_REQ,
  input  logic [ADDR_W-1:0] AUX_ADDR,
  output logic              AUX_GNT,
  output logic [DATA_W-1:0] AUX_DATA,
  output logic              AUX_VALID,
  output logic [ADDR_W-1:0] ROM_ADDR,
  output logic              ROM_RDEN,
  input  logic [DATA_W-1:0] ROM_Q,
  output logic [15:0]       AUX_STARVE_CNT
);

  typedef enum logic {
    IDLE     = 1'b0,
    AUX_WAIT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rom_addr_q;
  logic [ROM_LAT:0]    tag_vld_q;
  logic [ROM_LAT:0]    tag_aux_q;
  logic                pix_valid_q, aux_valid_q;
  logic [DATA_W-1:0]   pix_data_q, aux_data_q;
  logic                aux_gnt;
  logic                issue;
  logic                ret_pix, ret_aux;

  assign aux_gnt = AUX_REQ & ~PIX_REQ & (state_q == IDLE) & ~RESET;
  assign issue   = PIX_REQ | aux_gnt;

  // Tag at the last stage lines up with the word currently on ROM_Q.
  assign ret_pix = tag_vld_q[ROM_LAT] & ~tag_aux_q[ROM_LAT];
  assign ret_aux = tag_vld_q[ROM_LAT] &  tag_aux_q[ROM_LAT];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (aux_gnt) state_d = AUX_WAIT;
      AUX_WAIT: if (ret_aux) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge VGA_CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      rom_addr_q  <= '0;
      tag_vld_q   <= '0;
      tag_aux_q   <= '0;
      pix_valid_q <= 1'b0;
      aux_valid_q <= 1'b0;
      pix_data_q  <= '0;
      aux_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      if (issue) rom_addr_q <= PIX_REQ ? PIX_ADDR : AUX_ADDR;
      tag_vld_q   <= {tag_vld_q[ROM_LAT-1:0], issue};
      tag_aux_q   <= {tag_aux_q[ROM_LAT-1:0], ~PIX_REQ};
      pix_valid_q <= ret_pix;
      aux_valid_q <= ret_aux;
      if (ret_pix) pix_data_q <= ROM_Q;
      if (ret_aux) aux_data_q <= ROM_Q;
    end
  end

`ifdef IMAGE_ROM_ARB_STARVE_CNT_EN
  logic [15:0] starve_q, starve_d;

  always_comb begin
    starve_d = starve_q;
    if (!AUX_REQ || aux_gnt)    starve_d = '0;
    else if (starve_q != 16'hFFFF) starve_d = starve_q + 16'd1;
  end

  always_ff @(posedge VGA_CLK or posedge RESET) begin
    if (RESET) starve_q <= '0;
    else       starve_q <= starve_d;
  end

  assign AUX_STARVE_CNT = starve_q;
`else
  assign AUX_STARVE_CNT = '0;
`endif

  assign AUX_GNT   = aux_gnt;
  assign ROM_ADDR  = rom_addr_q;
  assign ROM_RDEN  = tag_vld_q[0];
  assign PIX_VALID = pix_valid_q;
  assign PIX_DATA  = pix_data_q;
  assign AUX_VALID = aux_valid_q;
  assign AUX_DATA  = aux_data_q;

endmodule
